mbox_arb: RTL and testbench

Arbitrates the single MBOX request port among three requesters: front-end (FE), EBOX, and an internal cache-clearer (CCA) sweep engine. It sits between the EBOX memory-request outputs and the MBOX. It keeps one reference outstanding at a time, re-issues on retry, and sequences full-cache sweeps when the EBOX starts a CCA operation.

---
 rtl/mbox_arb_pkg.sv | 30 +++
 rtl/mbox_arb_cca_sweep.sv | 65 ++++++
 rtl/mbox_arb.sv | 154 +++++++++++++++
 tb/tb_mbox_arb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbox_arb_pkg.sv
// rtl/mbox_arb_pkg.sv - shared encodings and defaults for the MBOX request arbiter
//
// Purpose: mbox_src encoding, default sweep/starvation parameters, the
// latched-reference record and the sweep-step address helper.
// Ports: none (package).
package mbox_arb_pkg;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_FE   = 2'd1;
   localparam logic [1:0] SRC_EBOX = 2'd2;
   localparam logic [1:0] SRC_CCA  = 2'd3;

   localparam int SWEEP_LINES_DEF  = 512;
   localparam int STARVE_LIMIT_DEF = 4;

   // Everything latched into the output registers on a grant.
   typedef struct packed {
      logic [22:0] adr;
      logic        write;
      logic        cca;
      logic [1:0]  src;
   } mref_t;

   // A sweep step addresses a cache line directly: the line index sits in the
   // low nine bits of the 23-bit address, everything above it is zero.
   function automatic logic [22:0] sweep_adr(input logic [8:0] cnt);
      return {14'b0, cnt};
   endfunction

endpackage

// File: rtl/mbox_arb_cca_sweep.sv
// rtl/mbox_arb_cca_sweep.sv - cache-clearer sweep sequencer for the MBOX arbiter
//
// Purpose: tracks the line index of a full-cache sweep, whether a sweep is
// running, and whether its next step still needs to be granted.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cca_start     one-cycle pulse, starts a sweep when none is running
//   step_grant    arbiter granted the pending sweep step this edge
//   step_done     outstanding sweep step completed this edge
//   cca_busy      sweep in progress
//   cca_done      one-cycle pulse after the last step completes
//   step_pending  a sweep step is waiting for a grant
//   sweep_cnt     line index of the current step
module mbox_arb_cca_sweep
   import mbox_arb_pkg::*;
#(
   parameter int SWEEP_LINES = SWEEP_LINES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cca_start,
   input  logic       step_grant,
   input  logic       step_done,
   output logic       cca_busy,
   output logic       cca_done,
   output logic       step_pending,
   output logic [8:0] sweep_cnt
);

   localparam logic [8:0] LAST_LINE = 9'(SWEEP_LINES - 1);

   // High while a sweep step is held by the arbiter (including retries).
   logic step_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         cca_busy  <= 1'b0;
         cca_done  <= 1'b0;
         sweep_cnt <= 9'd0;
         step_out  <= 1'b0;
      end else begin
         cca_done <= 1'b0;
         if (step_grant) begin
            step_out <= 1'b1;
         end
         if (step_done) begin
            step_out <= 1'b0;
            if (sweep_cnt == LAST_LINE) begin
               sweep_cnt <= 9'd0;
               cca_busy  <= 1'b0;
               cca_done  <= 1'b1;
            end else begin
               sweep_cnt <= sweep_cnt + 9'd1;
            end
         end else if (cca_start && !cca_busy) begin
            // A start while a sweep runs is dropped on purpose.
            cca_busy  <= 1'b1;
            sweep_cnt <= 9'd0;
         end
      end
   end

   assign step_pending = cca_busy && !step_out;

endmodule

// File: rtl/mbox_arb.sv
// rtl/mbox_arb.sv - single-outstanding MBOX request arbiter for FE, EBOX and cache sweep
//
// Purpose: grants the MBOX request port to FE, EBOX or the sweep engine, keeps
// one reference outstanding, re-issues on retry and acknowledges completion.
// Ports:
//   clk, CROBAR                  clock, synchronous active-high reset
//   fe_req/fe_adr/fe_write       FE request (level, held until fe_ack)
//   ebox_req/ebox_adr/ebox_write EBOX request (level, held until ebox_ack)
//   cca_start                    pulse, starts a cache sweep
//   mbox_resp, mbox_retry        MBOX completion / re-issue pulses
//   mbox_req/adr/write/cca/src   registered outstanding reference
//   fe_ack, ebox_ack             completion pulses
//   cca_busy, cca_done           sweep status
module mbox_arb
   import mbox_arb_pkg::*;
#(
   parameter int SWEEP_LINES  = SWEEP_LINES_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        CROBAR,
   input  logic        fe_req,
   input  logic [22:0] fe_adr,
   input  logic        fe_write,
   input  logic        ebox_req,
   input  logic [22:0] ebox_adr,
   input  logic        ebox_write,
   input  logic        cca_start,
   input  logic        mbox_resp,
   input  logic        mbox_retry,
   output logic        mbox_req,
   output logic [22:0] mbox_adr,
   output logic        mbox_write,
   output logic        mbox_cca,
   output logic [1:0]  mbox_src,
   output logic        fe_ack,
   output logic        ebox_ack,
   output logic        cca_busy,
   output logic        cca_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_RETRY = 2'd2;

   localparam int              SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

   logic [1:0]    state;
   logic [SW-1:0] starve_cnt;
   logic          step_pending;
   logic          step_grant;
   logic          step_done;
   logic [8:0]    sweep_cnt;
   mref_t         fe_ref;
   mref_t         ebox_ref;
   mref_t         cca_ref;
   mref_t         grant;

   assign fe_ref   = '{adr: fe_adr, write: fe_write, cca: 1'b0, src: SRC_FE};
   assign ebox_ref = '{adr: ebox_adr, write: ebox_write, cca: 1'b0, src: SRC_EBOX};
   assign cca_ref  = '{adr: sweep_adr(sweep_cnt), write: 1'b0, cca: 1'b1, src: SRC_CCA};

   // A requester whose ack is showing this cycle is still holding its old
   // request; masking it keeps the just-finished reference from a second grant.
   always_comb begin
      grant = '0;
      if (state == ST_IDLE) begin
         if (step_pending && starve_cnt == STARVE_MAX) begin
            grant = cca_ref;
         end else if (fe_req && !fe_ack) begin
            grant = fe_ref;
         end else if (ebox_req && !ebox_ack) begin
            grant = ebox_ref;
         end else if (step_pending) begin
            grant = cca_ref;
         end
      end
   end

   assign step_grant = (grant.src == SRC_CCA);
   // Retry outranks a simultaneous response, so only a clean response retires.
   assign step_done  = (state == ST_BUSY) && mbox_resp && !mbox_retry && (mbox_src == SRC_CCA);

   always_ff @(posedge clk) begin
      if (CROBAR) begin
         state      <= ST_IDLE;
         mbox_req   <= 1'b0;
         mbox_adr   <= 23'd0;
         mbox_write <= 1'b0;
         mbox_cca   <= 1'b0;
         mbox_src   <= SRC_NONE;
         fe_ack     <= 1'b0;
         ebox_ack   <= 1'b0;
         starve_cnt <= '0;
      end else begin
         fe_ack   <= 1'b0;
         ebox_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant.src != SRC_NONE) begin
                  state      <= ST_BUSY;
                  mbox_req   <= 1'b1;
                  mbox_adr   <= grant.adr;
                  mbox_write <= grant.write;
                  mbox_cca   <= grant.cca;
                  mbox_src   <= grant.src;
               end
            end
            ST_BUSY: begin
               if (mbox_retry) begin
                  state    <= ST_RETRY;
                  mbox_req <= 1'b0;
               end else if (mbox_resp) begin
                  state    <= ST_IDLE;
                  mbox_req <= 1'b0;
                  mbox_cca <= 1'b0;
                  mbox_src <= SRC_NONE;
                  fe_ack   <= (mbox_src == SRC_FE);
                  ebox_ack <= (mbox_src == SRC_EBOX);
               end
            end
            ST_RETRY: begin
               // Address, write and source registers are untouched, so the
               // re-issue is identical to the original reference.
               state    <= ST_BUSY;
               mbox_req <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase

         if (!cca_busy || step_grant) begin
            starve_cnt <= '0;
         end else if (grant.src != SRC_NONE && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   mbox_arb_cca_sweep #(
      .SWEEP_LINES (SWEEP_LINES)
   ) u_sweep (
      .clk          (clk),
      .rst          (CROBAR),
      .cca_start    (cca_start),
      .step_grant   (step_grant),
      .step_done    (step_done),
      .cca_busy     (cca_busy),
      .cca_done     (cca_done),
      .step_pending (step_pending),
      .sweep_cnt    (sweep_cnt)
   );

endmodule

// File: tb/tb_mbox_arb.sv
// tb/tb_mbox_arb.sv - scoreboard testbench for mbox_arb
//
// Purpose: drives FE/EBOX/sweep traffic and an MBOX responder, predicts every
// grant, ack, cca_done and cca_busy value from the arbitration rules, and a
// separate monitor compares the DUT against those predictions.
// Ports: none (top-level bench).
module tb_mbox_arb;
   import mbox_arb_pkg::*;

   localparam int SL  = 8;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        CROBAR = 1'b1;
   logic        fe_req = 1'b0, ebox_req = 1'b0;
   logic [22:0] fe_adr = '0, ebox_adr = '0;
   logic        fe_write = 1'b0, ebox_write = 1'b0;
   logic        cca_start = 1'b0, mbox_resp = 1'b0, mbox_retry = 1'b0;
   logic        mbox_req, mbox_write, mbox_cca, fe_ack, ebox_ack, cca_busy, cca_done;
   logic [22:0] mbox_adr;
   logic [1:0]  mbox_src;

   mbox_arb #(.SWEEP_LINES(SL), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .CROBAR(CROBAR),
      .fe_req(fe_req), .fe_adr(fe_adr), .fe_write(fe_write),
      .ebox_req(ebox_req), .ebox_adr(ebox_adr), .ebox_write(ebox_write),
      .cca_start(cca_start), .mbox_resp(mbox_resp), .mbox_retry(mbox_retry),
      .mbox_req(mbox_req), .mbox_adr(mbox_adr), .mbox_write(mbox_write),
      .mbox_cca(mbox_cca), .mbox_src(mbox_src), .fe_ack(fe_ack), .ebox_ack(ebox_ack),
      .cca_busy(cca_busy), .cca_done(cca_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   bit rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= CROBAR;
   end

   typedef struct {int cyc; logic [1:0] src; logic [22:0] adr; logic wr; logic cca;} gnt_t;
   typedef struct {int cyc; logic [1:0] src;} ack_t;
   typedef struct {logic [22:0] adr; logic wr;} txn_t;

   gnt_t gq[$];
   ack_t aq[$];
   int   dq[$];
   bit   exp_busy[int];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic miss(input string name, input int act, input int exp);
      n_chk++;
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, exp);
   endtask

   task automatic take_ack(input logic [1:0] s);
      ack_t a;
      if (aq.size() == 0) begin
         miss("unexpected_ack_src", int'(s), 0);
      end else begin
         a = aq.pop_front();
         chk("ack_cycle", 32'(cyc), 32'(a.cyc));
         chk("ack_src", 32'(s), 32'(a.src));
      end
   endtask

   // Monitor: runs on the falling edge, before the driver moves inputs.
   initial begin
      logic prev_req;
      gnt_t g;
      int   d;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            chk("reset_outputs", {mbox_req, mbox_adr, mbox_write, mbox_cca, mbox_src,
                                  fe_ack, ebox_ack, cca_busy, cca_done}, 32'd0);
            prev_req = 1'b0;
         end else begin
            if (exp_busy.exists(cyc)) chk("cca_busy", 32'(cca_busy), 32'(exp_busy[cyc]));
            if (mbox_req && !prev_req) begin
               if (gq.size() == 0) begin
                  miss("unexpected_grant_src", int'(mbox_src), 0);
               end else begin
                  g = gq.pop_front();
                  chk("grant_cycle", 32'(cyc), 32'(g.cyc));
                  chk("grant_src", 32'(mbox_src), 32'(g.src));
                  chk("grant_adr", 32'(mbox_adr), 32'(g.adr));
                  chk("grant_write", 32'(mbox_write), 32'(g.wr));
                  chk("grant_cca", 32'(mbox_cca), 32'(g.cca));
               end
            end
            if (fe_ack) take_ack(SRC_FE);
            if (ebox_ack) take_ack(SRC_EBOX);
            if (cca_done) begin
               if (dq.size() == 0) begin
                  miss("unexpected_cca_done", 1, 0);
               end else begin
                  d = dq.pop_front();
                  chk("cca_done_cycle", 32'(cyc), 32'(d));
               end
            end
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
               g = gq.pop_front();
               miss("missing_grant_cycle", 0, g.cyc);
            end
            while (aq.size() > 0 && aq[0].cyc < cyc) begin
               miss("missing_ack_cycle", 0, aq[0].cyc);
               void'(aq.pop_front());
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
               miss("missing_cca_done_cycle", 0, dq[0]);
               void'(dq.pop_front());
            end
            prev_req = mbox_req;
         end
      end
   end

   // Reference model state: one outstanding reference, sweep position,
   // starvation count and the per-requester pending work.
   bit         m_busy = 0, m_gap = 0, m_sw = 0, mask_fe = 0, mask_eb = 0, m_force_retry = 0;
   logic [1:0] m_src = SRC_NONE;
   logic [22:0] m_adr = '0;
   logic       m_wr = 0;
   int         m_age = 0, m_delay = 1, m_starve = 0, m_idx = 0;
   int         resp_min = 1, resp_max = 1, p_retry = 0, p_stray = 0;
   txn_t       feq[$], ebq[$];

   task automatic push_grant(input int c);
      m_busy  = 1;
      m_age   = 0;
      m_delay = int'($urandom_range(resp_max, resp_min));
      gq.push_back('{c + 1, m_src, m_adr, m_wr, m_src == SRC_CCA});
   endtask

   task automatic model_reset(input int c);
      m_busy = 0; m_gap = 0; m_sw = 0; m_idx = 0; m_starve = 0;
      mask_fe = 0; mask_eb = 0; m_force_retry = 0;
      feq.delete(); ebq.delete();
      while (gq.size() > 0 && gq[$].cyc > c) void'(gq.pop_back());
      while (aq.size() > 0 && aq[$].cyc > c) void'(aq.pop_back());
      while (dq.size() > 0 && dq[$] > c) void'(dq.pop_back());
   endtask

   // One clock of stimulus plus the model's view of the coming edge.
   task automatic step(input bit start, input bit rst);
      bit d_resp, d_retry, fe_v, eb_v, nm_fe, nm_eb, old_sw;
      logic [1:0] g;
      int c;
      @(negedge clk);
      #1;
      c = cyc;
      d_resp = 0;
      d_retry = 0;
      if (m_busy) begin
         m_age++;
         if (m_age >= m_delay) begin
            if (m_force_retry) begin
               d_retry = 1;
               m_force_retry = 0;
            end else if (int'($urandom_range(99)) < p_retry) begin
               d_retry = 1;
               d_resp = 1'($urandom_range(1));
            end else begin
               d_resp = 1;
            end
         end
      end else if (!m_gap && int'($urandom_range(99)) < p_stray) begin
         d_resp = 1'($urandom_range(1));
         d_retry = !d_resp;
      end
      fe_v = feq.size() > 0;
      eb_v = ebq.size() > 0;
      CROBAR = rst;
      cca_start = start;
      mbox_resp = d_resp;
      mbox_retry = d_retry;
      fe_req = fe_v;
      ebox_req = eb_v;
      // Once a request has been taken its address lines are scrambled.
      if (fe_v && !((m_busy || m_gap) && m_src == SRC_FE)) begin
         fe_adr = feq[0].adr; fe_write = feq[0].wr;
      end else begin
         fe_adr = 23'($urandom); fe_write = 1'($urandom_range(1));
      end
      if (eb_v && !((m_busy || m_gap) && m_src == SRC_EBOX)) begin
         ebox_adr = ebq[0].adr; ebox_write = ebq[0].wr;
      end else begin
         ebox_adr = 23'($urandom); ebox_write = 1'($urandom_range(1));
      end
      if (rst) begin
         model_reset(c);
         return;
      end

      old_sw = m_sw;
      nm_fe = 0;
      nm_eb = 0;
      g = SRC_NONE;
      if (m_busy) begin
         if (d_retry) begin
            m_busy = 0;
            m_gap = 1;
         end else if (d_resp) begin
            m_busy = 0;
            if (m_src == SRC_FE) begin
               aq.push_back('{c + 1, SRC_FE});
               void'(feq.pop_front());
               nm_fe = 1;
            end else if (m_src == SRC_EBOX) begin
               aq.push_back('{c + 1, SRC_EBOX});
               void'(ebq.pop_front());
               nm_eb = 1;
            end else if (m_idx == SL - 1) begin
               dq.push_back(c + 1);
               m_sw = 0;
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
      end else if (m_gap) begin
         m_gap = 0;
         push_grant(c);
      end else begin
         if (old_sw && m_starve == LIM) g = SRC_CCA;
         else if (fe_v && !mask_fe)     g = SRC_FE;
         else if (eb_v && !mask_eb)     g = SRC_EBOX;
         else if (old_sw)               g = SRC_CCA;
         if (g != SRC_NONE) begin
            m_src = g;
            if (g == SRC_FE) begin
               m_adr = fe_adr; m_wr = fe_write;
            end else if (g == SRC_EBOX) begin
               m_adr = ebox_adr; m_wr = ebox_write;
            end else begin
               m_adr = 23'(m_idx); m_wr = 0;
            end
            push_grant(c);
         end
      end
      if (!old_sw || g == SRC_CCA) m_starve = 0;
      else if (g != SRC_NONE && m_starve < LIM) m_starve++;
      if (start && !old_sw) begin
         m_sw = 1;
         m_idx = 0;
      end
      mask_fe = nm_fe;
      mask_eb = nm_eb;
      exp_busy[c + 1] = m_sw;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((m_busy || m_gap || m_sw || feq.size() > 0 || ebq.size() > 0) && n < budget) begin
         step(0, 0);
         n++;
      end
      if (m_busy || m_gap || m_sw || feq.size() > 0 || ebq.size() > 0) miss(name, n, budget);
      step(0, 0);
      step(0, 0);
   endtask

   initial begin
      int n;
      repeat (3) step(0, 1);

      resp_min = 3; resp_max = 3;
      ebq.push_back('{23'h001234, 1'b0});
      wait_idle(50, "timeout_ebox_read");

      feq.push_back('{23'($urandom), 1'b1});
      ebq.push_back('{23'($urandom), 1'b0});
      wait_idle(50, "timeout_simultaneous");

      feq.push_back('{23'h7FFFFF, 1'b1});
      m_force_retry = 1;
      wait_idle(50, "timeout_retry");

      resp_min = 1; resp_max = 1;
      step(1, 0);
      wait_idle(200, "timeout_full_sweep");

      for (int i = 0; i < 12; i++) begin
         feq.push_back('{23'($urandom), 1'($urandom_range(1))});
         ebq.push_back('{23'($urandom), 1'($urandom_range(1))});
      end
      step(1, 0);
      wait_idle(1000, "timeout_starvation");

      step(1, 0);
      n = 0;
      while (!(m_busy && m_src == SRC_CCA && m_idx == 3) && n < 100) begin
         step(0, 0);
         n++;
      end
      if (!(m_busy && m_src == SRC_CCA && m_idx == 3)) miss("timeout_reach_step3", n, 100);
      step(0, 1);
      step(0, 1);
      step(1, 0);
      wait_idle(200, "timeout_sweep_after_reset");

      resp_min = 1; resp_max = 4; p_retry = 20; p_stray = 10;
      for (int i = 0; i < 3000; i++) begin
         if (feq.size() < 2 && $urandom_range(99) < 15)
            feq.push_back('{23'($urandom), 1'($urandom_range(1))});
         if (ebq.size() < 2 && $urandom_range(99) < 15)
            ebq.push_back('{23'($urandom), 1'($urandom_range(1))});
         step(($urandom_range(99) == 0), (i == 1500));
      end
      p_stray = 0;
      wait_idle(5000, "timeout_random_drain");

      repeat (4) step(0, 0);
      if (gq.size() != 0) miss("leftover_grants", gq.size(), 0);
      if (aq.size() != 0) miss("leftover_acks", aq.size(), 0);
      if (dq.size() != 0) miss("leftover_cca_done", dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
